// File: rtl/led_blink_code.sv
// Status-code LED sequencer: blinks the LED N times for status code N, then a dark pause, then repeats.
// Latency: the LED lights one clock after an enabled nonzero code is sampled in IDLE; all outputs are registered.
// Backpressure: none; advances only on 1 ms ticks, and dropping the enable aborts to IDLE on the next clock.
module led_blink_code #(
  parameter int G_CODE_W   = 4,
  parameter int G_ON_MS    = 200,
  parameter int G_OFF_MS   = 300,
  parameter int G_PAUSE_MS = 1500,
  parameter int G_CNT_W    = 16
) (
  input  logic                p_in_clk,
  input  logic                p_in_rst_n,
  input  logic                p_in_tick,
  input  logic                p_in_en,
  input  logic [G_CODE_W-1:0] p_in_code,
  output logic                p_out_led,
  output logic                p_out_busy,
  output logic                p_out_seq_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_PAUSE
  } state_t;

  // Terminal counts: a state ends on the tick that finds the counter at P-1,
  // so each timed state spans exactly P ticks counted after its entry edge.
  localparam logic [G_CNT_W-1:0]  ON_LAST    = G_CNT_W'(G_ON_MS - 1);
  localparam logic [G_CNT_W-1:0]  OFF_LAST   = G_CNT_W'(G_OFF_MS - 1);
  localparam logic [G_CNT_W-1:0]  PAUSE_LAST = G_CNT_W'(G_PAUSE_MS - 1);
  localparam logic [G_CNT_W-1:0]  CNT_ONE    = G_CNT_W'(1);
  localparam logic [G_CODE_W-1:0] PULSE_ONE  = G_CODE_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [G_CNT_W-1:0]  tick_cnt;
  logic [G_CNT_W-1:0]  tick_cnt_nxt;
  logic [G_CODE_W-1:0] pulse_cnt;
  logic [G_CODE_W-1:0] pulse_cnt_nxt;
  logic [G_CODE_W-1:0] code_lat;
  logic [G_CODE_W-1:0] code_lat_nxt;
  logic                done_nxt;
  logic [G_CNT_W-1:0]  last_cnt;
  logic                tick_last;

  // Select the terminal count of the current timed state and flag its final tick.
  always_comb begin
    last_cnt = PAUSE_LAST;
    case (state)
      ST_ON:   last_cnt = ON_LAST;
      ST_OFF:  last_cnt = OFF_LAST;
      default: last_cnt = PAUSE_LAST;
    endcase
    tick_last = p_in_tick && (tick_cnt == last_cnt);
  end

  // Next-state logic: enable drop wins over every tick-driven transition.
  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    pulse_cnt_nxt = pulse_cnt;
    code_lat_nxt  = code_lat;
    done_nxt      = 1'b0;

    if ((state != ST_IDLE) && !p_in_en) begin
      state_nxt     = ST_IDLE;
      tick_cnt_nxt  = '0;
      pulse_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Start immediately on an enabled nonzero code; ticks here are ignored.
          if (p_in_en && (p_in_code != '0)) begin
            code_lat_nxt  = p_in_code;
            pulse_cnt_nxt = PULSE_ONE;
            tick_cnt_nxt  = '0;
            state_nxt     = ST_ON;
          end
        end

        ST_ON: begin
          if (tick_last) begin
            tick_cnt_nxt = '0;
            state_nxt    = ST_OFF;
          end else if (p_in_tick) begin
            tick_cnt_nxt = tick_cnt + CNT_ONE;
          end
        end

        ST_OFF: begin
          if (tick_last) begin
            tick_cnt_nxt = '0;
            // Equality against the latched code lets the all-ones code finish without wrapping.
            if (pulse_cnt == code_lat) begin
              state_nxt = ST_PAUSE;
            end else begin
              pulse_cnt_nxt = pulse_cnt + PULSE_ONE;
              state_nxt     = ST_ON;
            end
          end else if (p_in_tick) begin
            tick_cnt_nxt = tick_cnt + CNT_ONE;
          end
        end

        ST_PAUSE: begin
          if (tick_last) begin
            tick_cnt_nxt  = '0;
            pulse_cnt_nxt = '0;
            done_nxt      = 1'b1;
            state_nxt     = ST_IDLE;
          end else if (p_in_tick) begin
            tick_cnt_nxt = tick_cnt + CNT_ONE;
          end
        end

        default: begin
          state_nxt     = ST_IDLE;
          tick_cnt_nxt  = '0;
          pulse_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      pulse_cnt <= '0;
      code_lat  <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      code_lat  <= code_lat_nxt;
    end
  end

  // Outputs registered from the next state so they line up with the state change.
  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      p_out_led      <= 1'b0;
      p_out_busy     <= 1'b0;
      p_out_seq_done <= 1'b0;
    end else begin
      p_out_led      <= (state_nxt == ST_ON);
      p_out_busy     <= (state_nxt != ST_IDLE);
      p_out_seq_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_code.sv
// Bench for led_blink_code: timeline reference model feeding an event scoreboard.
// Latency: expected LED/busy/done edges are predicted per clock edge from a pre-drawn tick schedule.
// Backpressure: not applicable; the monitor pops one expected event per observed output change.
module tb_led_blink_code;

  localparam int ON    = 2;
  localparam int OFF   = 3;
  localparam int PAUSE = 5;
  localparam int PER   = ON + OFF;
  localparam int MAXC  = 20000;
  localparam int NEVER = 2 * MAXC;

  // Event kinds as seen on the outputs.
  localparam int K_LED_RISE  = 0;
  localparam int K_LED_FALL  = 1;
  localparam int K_BUSY_RISE = 2;
  localparam int K_BUSY_FALL = 3;
  localparam int K_DONE      = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic [3:0] code = 4'd0;
  logic       led;
  logic       busy;
  logic       done;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  tick_at [MAXC];
  ev_t sb [$];
  bit  pred_led;

  led_blink_code #(
    .G_CODE_W  (4),
    .G_ON_MS   (ON),
    .G_OFF_MS  (OFF),
    .G_PAUSE_MS(PAUSE),
    .G_CNT_W   (16)
  ) dut (
    .p_in_clk      (clk),
    .p_in_rst_n    (rst_n),
    .p_in_tick     (tick),
    .p_in_en       (en),
    .p_in_code     (code),
    .p_out_led     (led),
    .p_out_busy    (busy),
    .p_out_seq_done(done)
  );

  initial forever #5 clk = ~clk;

  // Edge counter: after posedge number n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Tick driver: tick_at[e] is the value sampled by the DUT at edge e.
  initial forever begin
    @(negedge clk);
    if (cyc + 1 < MAXC) tick = tick_at[cyc + 1];
    else tick = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    if (cyc >= MAXC - 20) begin
      $display("FAIL watchdog: cycle %0d reached, limit %0d", cyc, MAXC - 20);
      $fatal(1, "bench exceeded cycle budget");
    end
  end

  // Tick schedules: 0 = every 4 clocks, 1 = every clock, 2 = random (about 1 in 3).
  task automatic fill(input int mode);
    for (int e = cyc + 2; e < MAXC; e++) begin
      case (mode)
        0:       tick_at[e] = (e % 4 == 0);
        1:       tick_at[e] = 1'b1;
        default: tick_at[e] = ($urandom_range(0, 2) == 0);
      endcase
    end
  endtask

  // Edge on which the k-th tick strictly after edge s is sampled.
  function automatic int nth(input int s, input int k);
    int e = s;
    int n = 0;
    while (n < k && e < MAXC - 1) begin
      e++;
      if (tick_at[e]) n++;
    end
    return e;
  endfunction

  task automatic add(input int kind, input int e, input int abort);
    ev_t v;
    if (e < abort) begin
      v.kind = kind;
      v.cyc  = e;
      sb.push_back(v);
      if (kind == K_LED_RISE) pred_led = 1'b1;
      if (kind == K_LED_FALL) pred_led = 1'b0;
    end
  endtask

  // Reference timeline for one sequence of code c sampled at edge s: pulse p is lit from
  // tick (p-1)*PER to (p-1)*PER+ON, the sequence ends at tick c*PER+PAUSE. An enable
  // drop sampled at edge 'abort' truncates it with no done pulse.
  task automatic predict(input int s, input int c, input int abort, output int d);
    pred_led = 1'b0;
    add(K_LED_RISE, s, abort);
    add(K_BUSY_RISE, s, abort);
    for (int p = 1; p <= c; p++) begin
      add(K_LED_FALL, nth(s, (p - 1) * PER + ON), abort);
      if (p < c) add(K_LED_RISE, nth(s, p * PER), abort);
    end
    d = nth(s, c * PER + PAUSE);
    add(K_BUSY_FALL, d, abort);
    add(K_DONE, d, abort);
    if (d >= abort) begin
      if (pred_led) add(K_LED_FALL, abort, NEVER);
      add(K_BUSY_FALL, abort, NEVER);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_seq(input int c, output int s);
    @(negedge clk);
    en   = 1'b1;
    code = 4'(c);
    s    = cyc + 1;
  endtask

  // Monitor: every output change or done pulse must match the head of the scoreboard.
  task automatic sb_pop(input int kind);
    ev_t v;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL ev_unexpected: kind %0d at cyc %0d, expected no event", kind, cyc);
    end else begin
      v = sb.pop_front();
      if (v.kind != kind || v.cyc != cyc) begin
        errors++;
        $display("FAIL ev_order: got kind %0d at cyc %0d, expected kind %0d at cyc %0d",
                 kind, cyc, v.kind, v.cyc);
      end
    end
  endtask

  initial begin
    logic pl;
    logic pb;
    pl = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pl = led;
        pb = busy;
      end else begin
        if (led !== pl) sb_pop(led ? K_LED_RISE : K_LED_FALL);
        if (busy !== pb) sb_pop(busy ? K_BUSY_RISE : K_BUSY_FALL);
        if (done === 1'b1) sb_pop(K_DONE);
        pl = led;
        pb = busy;
      end
    end
  end

  task automatic reset_mid(input int c, input bit in_off);
    int s;
    int d;
    int t;
    fill(2);
    start_seq(c, s);
    predict(s, c, NEVER, d);
    t = in_off ? nth(s, ON) : s;
    wait_cyc(t);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    code  = 4'd0;
    sb.delete();
    #1;
    chk(in_off ? "rst_off_busy" : "rst_on_busy", int'(busy), 0);
    chk(in_off ? "rst_off_led" : "rst_on_led", int'(led), 0);
    chk(in_off ? "rst_off_done" : "rst_on_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    start_seq(c, s);
    predict(s, c, NEVER, d);
    wait_cyc(s);
    code = 4'd0;
    wait_cyc(d + 3);
    chk("rst_restart_idle", int'(busy), 0);
  endtask

  initial begin
    int s;
    int d;
    int d2;
    int a;
    int cs[6];
    int st[6];

    fill(0);
    repeat (2) @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_led", int'(led), 0);
    chk("idle_busy", int'(busy), 0);

    // Code 3, tick every 4 clocks: one full sequence then idle.
    start_seq(3, s);
    predict(s, 3, NEVER, d);
    wait_cyc(s);
    code = 4'd0;
    wait_cyc(d + 3);
    chk("code3_idle_busy", int'(busy), 0);

    // Code 0 with enable high: nothing happens for 100 ticks.
    @(negedge clk);
    en   = 1'b1;
    code = 4'd0;
    repeat (400) @(negedge clk);
    chk("code0_led", int'(led), 0);
    chk("code0_busy", int'(busy), 0);

    // Code 2 changed to 5 during the first ON: 2 pulses, then a 5-pulse sequence.
    start_seq(2, s);
    predict(s, 2, NEVER, d);
    predict(d + 1, 5, NEVER, d2);
    wait_cyc(s);
    code = 4'd5;
    wait_cyc(d + 1);
    code = 4'd0;
    wait_cyc(d2 + 3);
    chk("chg_idle_busy", int'(busy), 0);

    // Enable dropped during the second ON of code 4, then a fresh sequence.
    start_seq(4, s);
    a = nth(s, PER) + 1;
    predict(s, 4, a, d);
    wait_cyc(a - 1);
    en = 1'b0;
    wait_cyc(a);
    chk("endrop_led", int'(led), 0);
    chk("endrop_busy", int'(busy), 0);
    chk("endrop_done", int'(done), 0);
    wait_cyc(a + 3);
    start_seq(4, s);
    predict(s, 4, NEVER, d);
    wait_cyc(s);
    code = 4'd0;
    wait_cyc(d + 3);

    // Asynchronous reset mid-OFF and mid-ON, each followed by a full sequence.
    reset_mid(3, 1'b1);
    reset_mid(int'($urandom_range(2, 15)), 1'b0);

    // Maximum code with a tick every clock, including on the IDLE->ON edge.
    fill(1);
    start_seq(15, s);
    predict(s, 15, NEVER, d);
    chk("max_seq_len", d - s, 15 * PER + PAUSE);
    wait_cyc(s);
    code = 4'd0;
    wait_cyc(d + 3);

    // Random back-to-back chain with random tick spacing and mid-sequence code changes.
    fill(2);
    for (int i = 0; i < 6; i++) cs[i] = int'($urandom_range(1, 15));
    start_seq(cs[0], s);
    for (int i = 0; i < 6; i++) begin
      st[i] = s;
      predict(s, cs[i], NEVER, d);
      s = d + 1;
    end
    for (int i = 0; i < 6; i++) begin
      wait_cyc(st[i]);
      code = (i < 5) ? 4'(cs[i + 1]) : 4'd0;
    end
    wait_cyc(d + 3);
    chk("chain_idle_busy", int'(busy), 0);

    repeat (10) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_blink_code.md
Name: led_blink_code

Overview:
- Status-code LED sequencer, one stage downstream of the 1 ms tick generator (fpga_test_01 p_out_1ms); its output drives the board dbg_led.
- Blinks the LED N times, where N is the current status code, then holds a long dark pause and repeats. A 4-bit status is readable by eye with no JTAG.
- All timing is counted in 1 ms ticks, so the block is independent of the clock frequency.

Parameters:
- G_CODE_W, 4, width of the status code input.
- G_ON_MS, 200, LED-on time per pulse, in ticks (must be >= 1).
- G_OFF_MS, 300, LED-off gap after each pulse, in ticks (must be >= 1).
- G_PAUSE_MS, 1500, dark pause after the last pulse of a sequence, in ticks (must be >= 1).
- G_CNT_W, 16, tick counter width; must hold max(G_ON_MS, G_OFF_MS, G_PAUSE_MS).

Ports:
- p_in_clk, in, 1, system clock (sysclk25 domain).
- p_in_rst_n, in, 1, asynchronous active-low reset.
- p_in_tick, in, 1, single-cycle 1 ms strobe from the tick generator.
- p_in_en, in, 1, sequencer enable.
- p_in_code, in, G_CODE_W, status code; 0 means no blinking.
- p_out_led, out, 1, registered LED drive, 1 = lit.
- p_out_busy, out, 1, registered, high while a sequence is active.
- p_out_seq_done, out, 1, registered one-cycle pulse when a sequence completes.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, tick counter=0, pulse counter=0, latched code=0. p_out_led=0, p_out_busy=0, p_out_seq_done=0.
- States: IDLE, ON, OFF, PAUSE. All outputs are registered from next-state.
  - p_out_led=1 only in ON.
  - p_out_busy=1 in ON, OFF and PAUSE.
- IDLE:
  - Exits when p_in_en=1 and p_in_code!=0, with no tick required. At that edge: latch code, pulse counter=1, tick counter=0, go to ON.
  - p_out_led rises one clock after the sampling cycle.
  - Ticks in IDLE are ignored.
  - If p_in_code=0 or p_in_en=0, stay in IDLE; p_out_led=0.
- Tick counting, in every timed state:
  - On entry the tick counter is 0. Each p_in_tick=1 cycle either advances the counter by 1 or, if counter==P-1, leaves the state and clears the counter.
  - Each state therefore lasts exactly P ticks (P = G_ON_MS, G_OFF_MS or G_PAUSE_MS).
  - A tick coinciding with the state-entry edge is not counted.
- ON: after G_ON_MS ticks go to OFF.
- OFF: after G_OFF_MS ticks:
  - if pulse counter == latched code, go to PAUSE;
  - otherwise increment the pulse counter and go to ON.
- PAUSE: after G_PAUSE_MS ticks:
  - assert p_out_seq_done for exactly one clock (same edge as the exit);
  - go to IDLE, which re-samples p_in_code on the next cycle.
- Code changes: p_in_code changes during ON, OFF or PAUSE are ignored. The new value applies only at the next IDLE sample.
- Enable drop: p_in_en=0 in any non-IDLE state forces IDLE at the next edge.
  - p_out_led=0, p_out_busy=0, counters cleared, no p_out_seq_done.
  - Takes priority over any tick-driven transition in the same cycle.
- Width rules: pulse counter is G_CODE_W bits. The maximum code (2^G_CODE_W-1) completes without wrap, and the comparison is equality against the latched code.
- Reset mid-sequence: the asynchronous return to reset values is immediate, and p_out_led drops without waiting for a clock.
- Back-to-back sequences: with a steady nonzero code, there is exactly one IDLE cycle between the end of PAUSE and the next ON.

Test Plan (G_ON_MS=2, G_OFF_MS=3, G_PAUSE_MS=5, tick every 4 clocks unless stated):
- en=1, code=3 -> three LED-high windows of 2 ticks each, separated by 3-tick gaps; 5-tick pause; one seq_done pulse 20 ticks after the first rise; busy high throughout.
- en=1, code=0 for 100 ticks -> p_out_led=0, busy=0, seq_done never asserted.
- code=2, change to 5 during the first ON -> current sequence gives exactly 2 pulses; after seq_done the next sequence gives exactly 5 pulses.
- en dropped during the second ON of code=4 -> next edge has led=0, busy=0, no seq_done. Re-enable -> a fresh sequence starts with pulse 1.
- rst_n asserted mid-OFF with no clock edge -> outputs are 0 immediately. After release, sequence restarts from IDLE with full counts.
- code=15 (max), tick every clock -> exactly 15 pulses with no wrap, seq_done after 80 ticks. A tick on the IDLE->ON edge does not shorten the first ON.
